demux_1to4_reg: RTL
===================

DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

Interface
REQ-001 Parameter WIDTH, default 2: data width of din and of each output channel.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 din  input  WIDTH  data word to route.
REQ-005 sel  input  2  destination channel in manual mode.
REQ-006 auto_mode  input  1  1 = internal round-robin pointer chooses the destination; 0 = sel chooses it.
REQ-007 load  input  1  word valid; a transfer occurs when load && ready at a clock edge.
REQ-008 ready  output  1  block can accept a word this cycle.
REQ-009 y0, y1, y2, y3  output  WIDTH each  registered channel outputs.
REQ-010 vld  output  4  vld[i] = 1 when yi holds a word for the current frame.
REQ-011 frame_done  output  1  one-cycle pulse when all four channels become valid.
REQ-012 frame_ack  input  1  consumer has taken the frame; releases the FULL state.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE (vld = 0), FILL (0 < vld < 4'b1111) and FULL (vld = 4'b1111).
REQ-014 ready SHALL be 1 in IDLE and FILL, and 0 in FULL.
REQ-015 On a transfer, din SHALL be written to y[dest] and vld[dest] set at that edge, giving 1-cycle latency; no other yi changes.
REQ-016 dest SHALL be sel when auto_mode = 0, and the internal 2-bit pointer ptr when auto_mode = 1.
REQ-017 ptr SHALL increment by 1 on each auto-mode transfer, wrapping 3 -> 0; it SHALL hold on manual transfers and when there is no transfer.
REQ-018 A manual transfer to a channel with vld set SHALL overwrite yi; vld and the FSM state stay unchanged (see REQ-028 for the macro variant).
REQ-019 The edge that sets the last clear vld bit SHALL move the FSM to FULL, and frame_done SHALL be 1 during the following cycle only.
REQ-020 In FULL, frame_ack = 1 at an edge SHALL clear vld to 0, reset ptr to 0, and return the FSM to IDLE; yi keep their values.
REQ-021 frame_ack SHALL be ignored outside FULL.
REQ-022 load SHALL be ignored in FULL, including when it coincides with frame_ack; a word is accepted no earlier than the cycle after the return to IDLE.
REQ-023 A change of auto_mode SHALL take effect on the next transfer and SHALL NOT alter ptr or vld.

Reset
REQ-024 While rst = 1, regardless of clk: y0..y3 = 0, vld = 0, ptr = 0, frame_done = 0, ready = 1, FSM = IDLE.
REQ-025 Reset asserted mid-frame SHALL discard all partial data, with no frame_done pulse.
REQ-026 The first transfer SHALL be possible at the first rising edge after rst deasserts.

Configuration
REQ-027 Macro DEMUX_OVERWRITE_ERR_EN SHALL control overwrite protection and add output port err (1 bit).
REQ-028 With DEMUX_OVERWRITE_ERR_EN defined:
  - a manual transfer to a channel with vld set SHALL leave yi unchanged;
  - err SHALL pulse 1 for the following cycle;
  - err SHALL reset to 0.
REQ-029 Without DEMUX_OVERWRITE_ERR_EN: port err SHALL be absent, and REQ-018 overwrite behaviour applies.

Verification
REQ-030 Auto fill: reset, auto_mode = 1, load 00, 01, 10, 11 on four consecutive cycles -> y0..y3 = 00, 01, 10, 11; vld = 1111; frame_done high for exactly one cycle; ready = 0.
REQ-031 Manual out-of-order: sel = 3, 1, 0, 2 with din = 11, 01, 00, 10 -> each yi equals its din, and frame_done fires only after the sel = 2 load.
REQ-032 FULL hold and release: hold load = 1 with din = 01 in FULL for 5 cycles, then frame_ack = 1 -> yi unchanged, vld = 0000, ready = 1 the next cycle, next auto load goes to y0.
REQ-033 Overwrite: manual sel = 1 with din = 01, then sel = 1 with din = 10 -> without macro y1 = 10, vld = 0010; with macro y1 = 01 and err pulses one cycle.
REQ-034 Reset mid-frame: two auto loads, then rst pulse between clock edges -> all outputs zero immediately, next auto load lands in y0.
REQ-035 Collision: load = 1 and frame_ack = 1 in the same FULL cycle -> word dropped, vld = 0000, no frame_done.

Source files
------------

// File: rtl/demux_1to4_reg.sv
// 1-to-4 registered demux that fills a four-word frame, manually (sel) or round-robin (auto_mode).
// Latency: 1 cycle from an accepted word to its channel output.
// Backpressure: ready drops while the frame is full and returns after frame_ack. Defining DEMUX_OVERWRITE_ERR_EN adds the err port.
module demux_1to4_reg #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sel,
    input  logic             auto_mode,
    input  logic             load,
    output logic             ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       vld,
    output logic             frame_done,
    input  logic             frame_ack
`ifdef DEMUX_OVERWRITE_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       vld_q, vld_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             done_d;
    logic             wr_en;
    logic [1:0]       dest;
    logic             xfer;
    logic [WIDTH-1:0] y_q [4];
`ifdef DEMUX_OVERWRITE_ERR_EN
    logic             err_q, err_d;
`endif

    assign ready = (state_q != FULL);
    assign xfer  = load && ready;
    assign dest  = auto_mode ? ptr_q : sel;

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
`ifdef DEMUX_OVERWRITE_ERR_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE, FILL: begin
                if (xfer) begin
`ifdef DEMUX_OVERWRITE_ERR_EN
                    // Only manual writes are protected; the auto pointer may revisit a channel.
                    if (!auto_mode && vld_q[dest]) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en       = 1'b1;
                        vld_d[dest] = 1'b1;
                    end
`else
                    wr_en       = 1'b1;
                    vld_d[dest] = 1'b1;
`endif
                    if (auto_mode) begin
                        ptr_d = ptr_q + 2'd1;
                    end
                end
                if (vld_d == 4'b1111) begin
                    state_d = FULL;
                    done_d  = 1'b1;
                end else if (vld_d != 4'b0000) begin
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FULL: begin
                if (frame_ack) begin
                    state_d = IDLE;
                    vld_d   = 4'b0000;
                    ptr_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 4'b0000;
                ptr_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vld_q      <= 4'b0000;
            ptr_q      <= 2'd0;
            frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            ptr_q      <= ptr_d;
            frame_done <= done_d;
            if (wr_en) begin
                y_q[dest] <= din;
            end
        end
    end

`ifdef DEMUX_OVERWRITE_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`endif

    assign vld = vld_q;
    assign y0  = y_q[0];
    assign y1  = y_q[1];
    assign y2  = y_q[2];
    assign y3  = y_q[3];

endmodule
